// File: rtl/kbd_fifo_ctrl.sv
// Keyboard scan-code FIFO: drains a keyboard receiver through a 3-state strobe FSM
// and serves CPU data/status reads with a one-cycle registered response.
module kbd_fifo_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kb_ready,
  input  logic [DW-1:0] kb_data,
  output logic          kb_rdn,
  input  logic          rd_req,
  input  logic          rd_sel,
  output logic          rd_valid,
  output logic [31:0]   rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          stall;
  logic          under;
  logic [DW-1:0] mem [DEPTH];

  logic          empty;
  logic          full;
  logic          offer;
  logic          push;
  logic          data_rd;
  logic          pop;
  logic          stall_set;
  logic          under_set;
  logic [31:0]   status;

  // Legality decisions all use the occupancy at the start of the cycle.
  always_comb begin
    empty     = (count == CW'(0));
    full      = (count == CW'(DEPTH));
    offer     = (state == IDLE) && kb_ready;
    push      = offer && !full;
    stall_set = offer && full;
    data_rd   = rd_req && !rd_sel;
    pop       = data_rd && !empty;
    under_set = data_rd && empty;
    status    = {20'd0, 8'(count), under, stall, full, empty};
  end

  // Drain FSM; the strobe is low exactly while the state is ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      kb_rdn <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state  <= ACK;
            kb_rdn <= 1'b0;
          end else begin
            kb_rdn <= 1'b1;
          end
        end
        ACK: begin
          state  <= SETTLE;
          kb_rdn <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          kb_rdn <= 1'b1;
        end
      endcase
    end
  end

  // Storage holds no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= kb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a status read clears them, but a same-cycle set event wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall <= 1'b0;
      under <= 1'b0;
    end else begin
      if (stall_set)             stall <= 1'b1;
      else if (rd_req && rd_sel) stall <= 1'b0;
      if (under_set)             under <= 1'b1;
      else if (rd_req && rd_sel) under <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (!rd_req)    rd_data <= '0;
      else if (rd_sel) rd_data <= status;
      else if (pop)    rd_data <= 32'(mem[rd_ptr]);
      else             rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_kbd_fifo_ctrl.sv
// Self-checking bench for kbd_fifo_ctrl: read responses are scored against a queue
// of expected values pushed when each request is driven.
module tb_kbd_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        kb_ready;
  logic [7:0]  kb_data;
  logic        kb_rdn;
  logic        rd_req;
  logic        rd_sel;
  logic        rd_valid;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [7:0]  src[$];
  logic [7:0]  mdl[$];

  kbd_fifo_ctrl #(.DEPTH(8), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .kb_ready (kb_ready),
    .kb_data  (kb_data),
    .kb_rdn   (kb_rdn),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read(input logic sel, input logic [31:0] exp, input string tag);
    rd_req = 1'b1;
    rd_sel = sel;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    rd_req = 1'b0;
  endtask

  // Emulates the keyboard receiver: head byte advances once the strobe is seen.
  task automatic feed(input int cycles, output int accepted);
    accepted = 0;
    for (int c = 0; c < cycles; c++) begin
      kb_ready = (src.size() != 0);
      kb_data  = (src.size() != 0) ? src[0] : 8'h00;
      tick();
      if (!kb_rdn && src.size() != 0) begin
        accepted++;
        mdl.push_back(src.pop_front());
      end
    end
    kb_ready = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    if (exp_q.size() != 0) check_eq("resp_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) check_eq("spurious_valid", 32'(rd_valid), 32'd0);
      else check_eq(tag_q.pop_front(), rd_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [7:0] b;
    rst = 1'b1; kb_ready = 1'b0; kb_data = 8'h00; rd_req = 1'b0; rd_sel = 1'b0;
    tick(); tick();
    check_eq("rst_rdn", 32'(kb_rdn), 32'd1);
    check_eq("rst_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_data", rd_data, 32'd0);
    rst = 1'b0;
    tick();

    // Single byte
    kb_ready = 1'b1; kb_data = 8'h1C;
    tick();
    kb_ready = 1'b0;
    check_eq("single_rdn_low", 32'(kb_rdn), 32'd0);
    tick();
    check_eq("single_rdn_high", 32'(kb_rdn), 32'd1);
    tick();
    read(1'b1, 32'h010, "single_status");
    read(1'b0, 32'h01C, "single_data");
    read(1'b1, 32'h001, "single_status_empty");
    drain();

    // Fill with 9 bytes, only 8 fit
    for (int i = 1; i <= 9; i++) src.push_back(8'(i));
    feed(30, acc);
    check_eq("fill_strobes", 32'(acc), 32'd8);
    src.delete();
    read(1'b1, 32'h086, "fill_status");
    kb_ready = 1'b1; kb_data = 8'h99;
    read(1'b1, 32'h082, "stall_cleared_sample");
    read(1'b0, 32'(mdl.pop_front()), "full_pop_data");
    kb_ready = 1'b0;
    check_eq("full_pop_no_push", 32'(kb_rdn), 32'd1);
    read(1'b1, 32'h074, "stall_set_wins");
    for (int i = 0; i < 7; i++) read(1'b0, 32'(mdl.pop_front()), "fill_data");
    read(1'b1, 32'h001, "fill_status_empty");

    // Empty read
    read(1'b0, 32'h000, "empty_data");
    read(1'b1, 32'h009, "under_status");
    read(1'b1, 32'h001, "under_cleared");
    drain();

    // Concurrent push and pop
    src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
    feed(12, acc);
    check_eq("conc_strobes", 32'(acc), 32'd3);
    kb_ready = 1'b1; kb_data = 8'hAA;
    mdl.push_back(8'hAA);
    read(1'b0, 32'(mdl.pop_front()), "conc_data");
    kb_ready = 1'b0;
    check_eq("conc_push", 32'(kb_rdn), 32'd0);
    tick(); tick();
    read(1'b1, 32'h030, "conc_status");
    for (int i = 0; i < 3; i++) read(1'b0, 32'(mdl.pop_front()), "conc_order");
    read(1'b1, 32'h001, "conc_status_empty");
    drain();

    // Pointer wrap over 20 bytes
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      kb_ready = 1'b1; kb_data = b;
      mdl.push_back(b);
      tick();
      kb_ready = 1'b0;
      check_eq("wrap_rdn", 32'(kb_rdn), 32'd0);
      if (i >= 3) read(1'b0, 32'(mdl.pop_front()), "wrap_data");
      else tick();
      tick();
    end
    for (int i = 0; i < 3; i++) read(1'b0, 32'(mdl.pop_front()), "wrap_tail");
    read(1'b1, 32'h001, "wrap_status");
    drain();

    // Reset during ACK
    kb_ready = 1'b1; kb_data = 8'h55;
    tick();
    kb_ready = 1'b0;
    check_eq("ack_rdn_low", 32'(kb_rdn), 32'd0);
    rst = 1'b1; rd_req = 1'b1; rd_sel = 1'b1;
    tick();
    rst = 1'b0; rd_req = 1'b0;
    check_eq("ack_rst_rdn", 32'(kb_rdn), 32'd1);
    check_eq("ack_rst_valid", 32'(rd_valid), 32'd0);
    tick();
    check_eq("ack_rst_no_resp", 32'(rd_valid), 32'd0);
    read(1'b1, 32'h001, "ack_rst_status");
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_fifo_ctrl.md
KBD_FIFO_CTRL -- requirements
Module: kbd_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes; SHALL be a power of two, 2..128.
REQ-002 Parameter DW, default 8, scan-code width; SHALL equal the keyboard data width.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port kb_ready  input  1  keyboard receiver holds at least one unread byte.
REQ-006 Port kb_data  input  DW  head byte of the keyboard receiver, valid while kb_ready=1.
REQ-007 Port kb_rdn  output  1  active-low pop strobe to the keyboard receiver (one-cycle low pulse).
REQ-008 Port rd_req  input  1  CPU read request, one cycle per access.
REQ-009 Port rd_sel  input  1  0 = data register, 1 = status register.
REQ-010 Port rd_valid  output  1  read response valid, exactly one cycle.
REQ-011 Port rd_data  output  32  read response data.

Function
REQ-012 Drain FSM states SHALL be IDLE, ACK and SETTLE; kb_rdn SHALL be 0 only in ACK.
REQ-013 IDLE with kb_ready=1 and FIFO not full: push kb_data at the tail on that edge; next state ACK.
REQ-014 IDLE with kb_ready=1 and FIFO full: no push, no strobe, stay IDLE; set sticky STALL.
REQ-015 ACK SHALL always go to SETTLE; SETTLE SHALL always go to IDLE; kb_ready is ignored in both.
REQ-016 Throughput: at most one byte accepted per 3 cycles; first push edge to kb_rdn low = 1 cycle.
REQ-017 A read with rd_req=1 in cycle N SHALL give rd_valid=1 with rd_data in cycle N+1; no back-pressure.
REQ-018 Data read, FIFO non-empty: rd_data = head byte zero-extended to 32 bits; head popped on the same edge.
REQ-019 Data read, FIFO empty: rd_data = 0, no pop; set sticky UNDER.
REQ-020 Status rd_data: bit0 EMPTY, bit1 FULL, bit2 STALL, bit3 UNDER, bits[11:4] count (zero-extended), rest 0.
REQ-021 The status value SHALL be sampled in cycle N; STALL and UNDER SHALL clear on that edge (read-to-clear).
REQ-022 If a sticky set event coincides with a status read, set SHALL win; the bit reads 1 on the next status read.
REQ-023 Push and pop on the same edge: both occur and count is unchanged; push legality uses full from cycle start.
REQ-024 A pop from a full FIFO in the same cycle as IDLE+kb_ready SHALL NOT enable a push that cycle.
REQ-025 Pop from an empty FIFO in the same cycle as a push: no bypass; return 0, set UNDER, and the pushed byte remains stored.
REQ-026 Pointers SHALL wrap modulo DEPTH; count width SHALL be log2(DEPTH)+1, range 0..DEPTH.
REQ-027 FIFO order SHALL be strictly first-in first-out; no byte duplicated or lost except under reset.

Reset
REQ-028 On rst=1 at an edge: state IDLE, pointers and count 0, STALL=UNDER=0, FIFO contents don't-care.
REQ-029 While rst=1 and on the cycle after: kb_rdn=1, rd_valid=0, rd_data=0.
REQ-030 Reset during ACK or SETTLE SHALL abort the strobe (kb_rdn=1 next cycle); the byte already pushed is discarded.
REQ-031 rd_req asserted in the reset cycle SHALL produce no response.

Verification
REQ-032 Single byte: kb_ready=1, kb_data=0x1C for 1 cycle -> kb_rdn low 1 cycle later; status reads 0x010; data read returns 0x0000001C, then status reads 0x001.
REQ-033 Fill: 9 bytes 0x01..0x09 offered back-to-back -> count 8, FULL=1, STALL=1, no 9th strobe; 8 data reads return 0x01..0x08 in order.
REQ-034 Empty read: data read on empty FIFO -> rd_data=0, UNDER set; status read returns 0x009; second status read returns 0x001.
REQ-035 Concurrent: FIFO holds 3, data read in the same cycle as push of 0xAA -> count stays 3; 0xAA is returned after the 2 older bytes.
REQ-036 Wrap: push and pop 20 bytes with DEPTH=8 -> data intact and in order across pointer wrap.
REQ-037 Reset in ACK: assert rst during ACK -> kb_rdn=1 next cycle, status 0x001, no response to a concurrent rd_req.
